data_mem_responder: RTL

- Memory-side responder for the RV32I core's load/store path: the target end of the MemRead/MemWrite interface the control unit drives.
- Accepts one load/store request per transaction over a valid/ready handshake. Performs byte/half/word access into an internal word-addressed array after a programmable latency.
- Returns sign- or zero-extended load data, or a store acknowledgement, with an error flag.
- Sits between the core datapath and data memory; replaces a single-cycle combinational memory.

---
 rtl/rv32i_mem_pkg.sv | 24 ++
 rtl/mem_lane_align.sv | 64 ++++++
 rtl/data_mem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/rv32i_mem_pkg.sv
// Shared types for the RV32I data-memory responder: funct3 codes, FSM states
// and the latched request record.
package rv32i_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte-enables and replicated write data,
// extended load data from the raw word, and the misalign/illegal-funct3 flag.
module mem_lane_align
    import rv32i_mem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = 8'h00;
        case (i_addr_lo)
            2'd0: w_byte = i_rword[7:0];
            2'd1: w_byte = i_rword[15:8];
            2'd2: w_byte = i_rword[23:16];
            default: w_byte = i_rword[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

        o_be    = 4'b0000;
        o_wdata = 32'h0;
        o_rdata = 32'h0;
        o_err   = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_err   = i_we && (i_funct3 == F3_BU);
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = (i_funct3 == F3_B) ? {{24{w_byte[7]}}, w_byte}
                                             : {24'h0, w_byte};
            end
            F3_H, F3_HU: begin
                o_err   = i_addr_lo[0] || (i_we && (i_funct3 == F3_HU));
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = (i_funct3 == F3_H) ? {{16{w_half[15]}}, w_half}
                                             : {16'h0, w_half};
            end
            F3_W: begin
                o_err   = (i_addr_lo != 2'b00);
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = i_rword;
            end
            default: o_err = 1'b1;
        endcase
        // An erroring access neither writes nor returns data.
        if (o_err) begin
            o_be    = 4'b0000;
            o_rdata = 32'h0;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Load/store target for the RV32I core: one request at a time over
// valid/ready, access after LATENCY cycles, response held until consumed.
module data_mem_responder
    import rv32i_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid side holds its payload until then, ready never depends on valid.

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;
    mem_req_t    r_req;
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic        w_accept;
    logic        w_commit;
    logic        w_rsp_hs;
    logic        w_oor;
    logic        w_align_err;
    logic        w_err;
    logic [AW-1:0] w_widx;
    logic [31:0] w_rword;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_al;
    logic [31:0] w_rdata_ext;

    assign req_ready = (r_state == IDLE) && !rst;
    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign dbg_state = r_state;

    assign w_oor   = (r_req.addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_widx  = r_req.addr[AW+1:2];
    assign w_rword = r_mem[w_widx];
    assign w_err   = w_align_err || w_oor;

    mem_lane_align u_align (
        .i_we      (r_req.we),
        .i_funct3  (r_req.funct3),
        .i_addr_lo (r_req.addr[1:0]),
        .i_wdata   (r_req.wdata),
        .i_rword   (w_rword),
        .o_be      (w_be),
        .o_wdata   (w_wdata_al),
        .o_rdata   (w_rdata_ext),
        .o_err     (w_align_err)
    );

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        w_rsp_hs     = 1'b0;
        case (r_state)
            IDLE: if (req_valid) begin
                w_accept     = 1'b1;
                w_next_state = WAIT;
            end
            WAIT: if (r_cnt == 4'd0) begin
                w_commit     = 1'b1;
                w_next_state = RESP;
            end
            RESP: if (rsp_ready) begin
                w_rsp_hs     = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_cnt <= LAT_M1;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_rdata <= (r_req.we || w_err) ? 32'h0 : w_rdata_ext;
                r_err   <= w_err;
            end else if (w_rsp_hs) begin
                r_rdata <= 32'h0;
                r_err   <= 1'b0;
            end
        end
    end

    // Request payload needs no reset: it is only consumed after an accept.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_req <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
        end
    end

    // Array contents survive reset; a reset on the commit edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_req.we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_widx][8*b +: 8] <= w_wdata_al[8*b +: 8];
                end
            end
        end
    end

endmodule
